adc_frame_scheduler: RTL and testbench
======================================

Name: adc_frame_scheduler

Overview:
- Sequences the AD7324 SPI engine (spi_ad7324) through frames of conversions over the enabled channels, on a fixed sample tick.
- Checks each returned channel ID against the channel requested, converts the 13-bit two's-complement result to offset binary, and holds the latest value per channel.
- Sits between spi_ad7324 and the compensator/LCD path, replacing ad-hoc HOLD pulsing with a single owner of the ADC.

Parameters:
- TICK_DIV, 2000: CLK cycles per frame tick (10 kHz at 20 MHz); legal range 16..65535.
- TIMEOUT, 64: CLK cycles allowed from SPI_START to SPI_DONE before the conversion is abandoned.
- M, 12: MSB index of the result; stored width is M+1.

Ports:
- CLK  in  1  20 MHz system clock (CLK20M domain).
- RSTp  in  1  synchronous active-high reset.
- EN  in  1  scheduler enable.
- CH_MASK  in  4  per-channel enable; bit0=Vout, 1=Temp, 2=Vin, 3=Iout.
- ERR_CLR  in  1  clears SEQ_ERR.
- SPI_START  out  1  one-cycle conversion request to the SPI engine.
- SPI_CH  out  2  channel address accompanying SPI_START.
- SPI_DONE  in  1  one-cycle strobe; SPI_DATA is valid in the same cycle.
- SPI_DATA  in  16  [14:13] channel ID, [12:0] two's-complement result.
- VOUT, TEMP, VIN, IOUT  out  M+1 each  latest offset-binary result for each channel.
- SAMPLE_VALID  out  1  one-cycle strobe when a channel register updates.
- SAMPLE_CH  out  2  channel updated; valid with SAMPLE_VALID.
- BUSY  out  1  high when state is not IDLE or WAIT_TICK.
- SEQ_ERR  out  3  sticky flags: [0] ID mismatch, [1] timeout, [2] tick overrun.

Behaviour:
- Reset (sync, RSTp=1): the following clear to 0 on the same edge, overriding any in-flight conversion:
  - state=IDLE, all outputs, tick counter, timeout counter, channel pointer.
- Tick counter:
  - Runs whenever EN=1; counts 0..TICK_DIV-1, then wraps.
  - tick = 1 for one cycle at the wrap.
  - Cleared while EN=0.
- FSM states: IDLE, WAIT_TICK, SELECT, ISSUE, WAIT_DONE, STORE.
  - IDLE: EN=1 -> WAIT_TICK.
  - WAIT_TICK: EN=0 -> IDLE. On tick: latch CH_MASK into frame_mask, pointer=0 -> SELECT.
  - SELECT: finds the lowest index >= pointer with frame_mask set.
    - Found: SPI_CH=index -> ISSUE.
    - None found (includes frame_mask=0): frame ends -> WAIT_TICK, or IDLE if EN=0.
  - ISSUE: SPI_START=1 for exactly one cycle; timeout counter cleared -> WAIT_DONE.
  - WAIT_DONE:
    - SPI_DONE=1 -> STORE, capturing SPI_DATA.
    - Counter reaches TIMEOUT-1 without SPI_DONE -> set SEQ_ERR[1], pointer=index+1 -> SELECT.
  - STORE:
    - ID matches SPI_CH: write the channel register with {~d[12], d[11:0]} (i.e. d+4096 mod 8192), pulse SAMPLE_VALID with SAMPLE_CH.
    - ID differs: set SEQ_ERR[0], no register write, no strobe.
    - Either case: pointer=index+1 -> SELECT.
- Latency:
  - tick to SPI_START = 2 cycles.
  - SPI_DONE to SAMPLE_VALID = 1 cycle.
  - End of one conversion to the next SPI_START = 2 cycles.
- EN deasserted mid-frame: the current conversion completes (or times out) and is stored; no further channels are issued; frame ends -> IDLE.
- CH_MASK changes mid-frame: ignored until the next tick (frame_mask is latched).
- Tick while BUSY: the tick is dropped and SEQ_ERR[2] is set; the frame continues.
- ERR_CLR and a new error in the same cycle: set wins for that bit; other bits clear.
- SPI_DONE outside WAIT_DONE: ignored.
- Channel registers hold their value across frames and are cleared only by reset.

Optional Feature:
- ADC_SCHED_AVG_EN defined:
  - Each channel keeps a 4-sample accumulator of width M+3.
  - The channel register updates, and SAMPLE_VALID pulses, only on every 4th valid sample for that channel, with value = accumulator>>2.
  - The accumulator clears after each update and on reset.
- Undefined: every valid sample updates immediately, as described above.

Decomposition:
- Shared package adc_sched_pkg:
  - Channel index constants CH_VOUT=0, CH_TEMP=1, CH_VIN=2, CH_IOUT=3.
  - FSM state encoding (4-bit, using the DFFA state-register style).
  - SEQ_ERR bit positions.
- One natural sub-module, adc_ch_select: combinational lowest-set-bit-at-or-above-pointer finder over 4 bits, returning found and index.

Test Plan:
- CH_MASK=4'b1111, ideal SPI model, DONE 20 cycles after START with matching IDs, data 13'h1000 (-4096) on all channels -> VOUT=TEMP=VIN=IOUT=13'h0000; SAMPLE_CH sequence 0,1,2,3; one frame per 2000 cycles.
- CH_MASK=4'b0101, data 13'h0FFF on channel 2 -> only channels 0 and 2 issued; VIN=13'h1FFF; TEMP and IOUT remain 0.
- Model returns ID 2'b11 for a request on channel 1 -> SEQ_ERR=3'b001, TEMP unchanged, no SAMPLE_VALID; frame continues to channel 2.
- Model never asserts DONE on channel 0 -> SEQ_ERR[1] set 64 cycles after START; SPI_START for channel 1 follows 1 cycle later.
- TICK_DIV=16, DONE delay 30, all channels enabled -> SEQ_ERR[2] set; ERR_CLR then clears it; RSTp pulsed mid-WAIT_DONE -> next cycle all outputs 0 and state IDLE.
- With ADC_SCHED_AVG_EN and channel 0 samples 13'h1000, 13'h1004, 13'h1008, 13'h100C (offset-binary 0, 4, 8, 12) -> SAMPLE_VALID once, after the 4th sample; VOUT=6.

Source files
------------

// File: rtl/adc_sched_pkg.sv
// Shared definitions for the ADC frame scheduler: channel indices,
// FSM state encoding and SEQ_ERR bit positions.
package adc_sched_pkg;

  localparam int NUM_CH = 4;

  // Channel addresses as presented on SPI_CH / SAMPLE_CH
  localparam logic [1:0] CH_VOUT = 2'd0;
  localparam logic [1:0] CH_TEMP = 2'd1;
  localparam logic [1:0] CH_VIN  = 2'd2;
  localparam logic [1:0] CH_IOUT = 2'd3;

  // Sticky error flag positions
  localparam int ERR_ID  = 0;
  localparam int ERR_TO  = 1;
  localparam int ERR_OVR = 2;

  // Scheduler states, 4-bit encoded state register
  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_WAIT_TICK = 4'd1,
    S_SELECT    = 4'd2,
    S_ISSUE     = 4'd3,
    S_WAIT_DONE = 4'd4,
    S_STORE     = 4'd5
  } state_e;

  // A frame is in progress in every state except the two resting states
  function automatic logic is_busy(input state_e s);
    return !((s == S_IDLE) || (s == S_WAIT_TICK));
  endfunction

endpackage

// File: rtl/adc_ch_select.sv
// Finds the lowest enabled channel at or above the frame pointer.
// A pointer of 4 (past the last channel) always yields found_o=0.
module adc_ch_select
  import adc_sched_pkg::*;
(
  input  logic [NUM_CH-1:0] mask_i,
  input  logic [2:0]        ptr_i,
  output logic              found_o,
  output logic [1:0]        idx_o
);

  // Scan downward so the lowest qualifying index is the last one written
  always_comb begin
    found_o = 1'b0;
    idx_o   = 2'd0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_i[i] && (3'(i) >= ptr_i)) begin
        found_o = 1'b1;
        idx_o   = 2'(i);
      end
    end
  end

endmodule

// File: rtl/adc_frame_scheduler.sv
// Single owner of the AD7324 SPI engine: on every frame tick it walks the
// enabled channels, issues one conversion each, checks the returned channel
// ID, converts the result to offset binary and holds it per channel.
// Optional build macro ADC_SCHED_AVG_EN: each channel register is updated
// with the mean of every four accepted samples instead of every sample.
module adc_frame_scheduler
  import adc_sched_pkg::*;
#(
  parameter int TICK_DIV = 2000,
  parameter int TIMEOUT  = 64,
  parameter int M        = 12
) (
  input  logic        CLK,
  input  logic        RSTp,
  input  logic        EN,
  input  logic [3:0]  CH_MASK,
  input  logic        ERR_CLR,
  output logic        SPI_START,
  output logic [1:0]  SPI_CH,
  input  logic        SPI_DONE,
  input  logic [15:0] SPI_DATA,
  output logic [M:0]  VOUT,
  output logic [M:0]  TEMP,
  output logic [M:0]  VIN,
  output logic [M:0]  IOUT,
  output logic        SAMPLE_VALID,
  output logic [1:0]  SAMPLE_CH,
  output logic        BUSY,
  output logic [2:0]  SEQ_ERR
);

  localparam int          TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

  state_e                   state_q;
  logic [15:0]              tick_cnt_q;
  logic                     tick;
  logic [NUM_CH-1:0]        mask_q;
  logic [2:0]               ptr_q;
  logic [TW-1:0]            to_cnt_q;
  logic                     spi_start_q;
  logic [1:0]               spi_ch_q;
  logic [NUM_CH-1:0][M:0]   ch_q;
  logic                     valid_q;
  logic [1:0]               samp_ch_q;
  logic [2:0]               err_q;

  logic                     sel_found;
  logic [1:0]               sel_idx;
  logic [M:0]               ob_d;
  logic                     id_ok_d;
  logic                     smp_d;
  logic [2:0]               err_set_d;
  logic                     unused_spi_msb;

  assign unused_spi_msb = SPI_DATA[15];

  // Free-running frame timebase, held at zero while disabled
  always_ff @(posedge CLK) begin
    if (RSTp || !EN) begin
      tick_cnt_q <= '0;
    end else if (tick_cnt_q == TICK_LAST) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + 16'd1;
    end
  end

  assign tick = EN && (tick_cnt_q == TICK_LAST);

  adc_ch_select u_sel (
    .mask_i  (mask_q),
    .ptr_i   (ptr_q),
    .found_o (sel_found),
    .idx_o   (sel_idx)
  );

  // Returned-sample decode: sign-bit flip gives d+2^M mod 2^(M+1)
  always_comb begin
    ob_d    = {~SPI_DATA[M], SPI_DATA[M-1:0]};
    id_ok_d = (SPI_DATA[14:13] == spi_ch_q);
    smp_d   = (state_q == S_WAIT_DONE) && SPI_DONE && id_ok_d;
  end

  // Error events raised this cycle
  always_comb begin
    err_set_d          = '0;
    err_set_d[ERR_ID]  = (state_q == S_WAIT_DONE) && SPI_DONE && !id_ok_d;
    err_set_d[ERR_TO]  = (state_q == S_WAIT_DONE) && !SPI_DONE && (to_cnt_q == TO_LAST);
    err_set_d[ERR_OVR] = tick && is_busy(state_q);
  end

  // Sequencer: tick -> walk enabled channels -> one conversion each
  always_ff @(posedge CLK) begin
    if (RSTp) begin
      state_q     <= S_IDLE;
      mask_q      <= '0;
      ptr_q       <= '0;
      to_cnt_q    <= '0;
      spi_start_q <= 1'b0;
      spi_ch_q    <= '0;
    end else begin
      spi_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (EN) state_q <= S_WAIT_TICK;
        end
        S_WAIT_TICK: begin
          if (!EN) begin
            state_q <= S_IDLE;
          end else if (tick) begin
            mask_q  <= CH_MASK;
            ptr_q   <= '0;
            state_q <= S_SELECT;
          end
        end
        S_SELECT: begin
          // Dropping EN stops further issues; the frame ends here
          if (EN && sel_found) begin
            spi_ch_q    <= sel_idx;
            spi_start_q <= 1'b1;
            to_cnt_q    <= '0;
            state_q     <= S_ISSUE;
          end else begin
            state_q <= EN ? S_WAIT_TICK : S_IDLE;
          end
        end
        S_ISSUE: begin
          to_cnt_q <= to_cnt_q + TW'(1);
          state_q  <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (SPI_DONE) begin
            state_q <= S_STORE;
          end else if (to_cnt_q == TO_LAST) begin
            ptr_q   <= {1'b0, spi_ch_q} + 3'd1;
            state_q <= S_SELECT;
          end else begin
            to_cnt_q <= to_cnt_q + TW'(1);
          end
        end
        S_STORE: begin
          ptr_q   <= {1'b0, spi_ch_q} + 3'd1;
          state_q <= S_SELECT;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Sticky errors; a new event beats a simultaneous clear for its bit
  always_ff @(posedge CLK) begin
    if (RSTp) begin
      err_q <= '0;
    end else begin
      err_q <= (ERR_CLR ? 3'b000 : err_q) | err_set_d;
    end
  end

`ifdef ADC_SCHED_AVG_EN
  logic [NUM_CH-1:0][M+2:0] acc_q;
  logic [NUM_CH-1:0][1:0]   acnt_q;
  logic [M+2:0]             acc_sum_d;

  assign acc_sum_d = acc_q[spi_ch_q] + {2'b00, ob_d};

  // Channel registers take the mean of every fourth accepted sample
  always_ff @(posedge CLK) begin
    if (RSTp) begin
      ch_q      <= '0;
      acc_q     <= '0;
      acnt_q    <= '0;
      valid_q   <= 1'b0;
      samp_ch_q <= '0;
    end else begin
      valid_q <= 1'b0;
      if (smp_d) begin
        if (acnt_q[spi_ch_q] == 2'd3) begin
          ch_q[spi_ch_q]   <= acc_sum_d[M+2:2];
          acc_q[spi_ch_q]  <= '0;
          acnt_q[spi_ch_q] <= 2'd0;
          valid_q          <= 1'b1;
          samp_ch_q        <= spi_ch_q;
        end else begin
          acc_q[spi_ch_q]  <= acc_sum_d;
          acnt_q[spi_ch_q] <= acnt_q[spi_ch_q] + 2'd1;
        end
      end
    end
  end
`else
  // Channel registers take every accepted sample; written on the DONE edge
  // so the strobe lands one cycle after SPI_DONE
  always_ff @(posedge CLK) begin
    if (RSTp) begin
      ch_q      <= '0;
      valid_q   <= 1'b0;
      samp_ch_q <= '0;
    end else begin
      valid_q <= smp_d;
      if (smp_d) begin
        ch_q[spi_ch_q] <= ob_d;
        samp_ch_q      <= spi_ch_q;
      end
    end
  end
`endif

  assign SPI_START    = spi_start_q;
  assign SPI_CH       = spi_ch_q;
  assign VOUT         = ch_q[CH_VOUT];
  assign TEMP         = ch_q[CH_TEMP];
  assign VIN          = ch_q[CH_VIN];
  assign IOUT         = ch_q[CH_IOUT];
  assign SAMPLE_VALID = valid_q;
  assign SAMPLE_CH    = samp_ch_q;
  assign BUSY         = is_busy(state_q);
  assign SEQ_ERR      = err_q;

endmodule

// File: tb/tb_adc_frame_scheduler.sv
// Directed bench for adc_frame_scheduler: a behavioural SPI engine answers
// each SPI_START after a programmable delay; a second instance with a short
// tick exercises overrun, error clear and mid-conversion reset.
module tb_adc_frame_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main instance ----------------
  logic        rst, en, err_clr, spi_start, spi_done, sval, busy;
  logic [3:0]  ch_mask;
  logic [1:0]  spi_ch, sch;
  logic [15:0] spi_data;
  logic [12:0] vout, temp, vin, iout;
  logic [2:0]  serr;

  adc_frame_scheduler u_dut (
    .CLK(clk), .RSTp(rst), .EN(en), .CH_MASK(ch_mask), .ERR_CLR(err_clr),
    .SPI_START(spi_start), .SPI_CH(spi_ch), .SPI_DONE(spi_done), .SPI_DATA(spi_data),
    .VOUT(vout), .TEMP(temp), .VIN(vin), .IOUT(iout),
    .SAMPLE_VALID(sval), .SAMPLE_CH(sch), .BUSY(busy), .SEQ_ERR(serr)
  );

  // ---------------- short-tick instance ----------------
  logic        rst2, en2, err_clr2, spi_start2, spi_done2, sval2, busy2;
  logic [3:0]  ch_mask2;
  logic [1:0]  spi_ch2, sch2;
  logic [15:0] spi_data2;
  logic [12:0] vout2, temp2, vin2, iout2;
  logic [2:0]  serr2;

  adc_frame_scheduler #(.TICK_DIV(16)) u_dut2 (
    .CLK(clk), .RSTp(rst2), .EN(en2), .CH_MASK(ch_mask2), .ERR_CLR(err_clr2),
    .SPI_START(spi_start2), .SPI_CH(spi_ch2), .SPI_DONE(spi_done2), .SPI_DATA(spi_data2),
    .VOUT(vout2), .TEMP(temp2), .VIN(vin2), .IOUT(iout2),
    .SAMPLE_VALID(sval2), .SAMPLE_CH(sch2), .BUSY(busy2), .SEQ_ERR(serr2)
  );

  // ---------------- SPI engine model (main) ----------------
  int          m_delay = 20;
  logic [12:0] m_data [4];
  int          m_badid_ch = -1;
  logic [1:0]  m_bad_id = 2'b11;
  int          m_nodone_ch = -1;
  bit          m_pend = 0;
  int          m_cnt = 0;
  logic [1:0]  m_ch = 2'd0;
  int          done_cyc = 0;

  always @(negedge clk) begin
    spi_done = 1'b0;
    if (m_pend) begin
      if (m_cnt <= 1) begin
        spi_done = 1'b1;
        spi_data = {1'b0, ((int'(m_ch) == m_badid_ch) ? m_bad_id : m_ch), m_data[m_ch]};
        m_pend   = 0;
        done_cyc = cyc;
      end else begin
        m_cnt--;
      end
    end
    if (spi_start === 1'b1 && int'(spi_ch) != m_nodone_ch) begin
      m_pend = 1;
      m_cnt  = m_delay;
      m_ch   = spi_ch;
    end
  end

  // ---------------- SPI engine model (short tick): delay 30, data 0 ----------------
  bit         m2_pend = 0;
  int         m2_cnt = 0;
  logic [1:0] m2_ch = 2'd0;

  always @(negedge clk) begin
    spi_done2 = 1'b0;
    if (m2_pend) begin
      if (m2_cnt <= 1) begin
        spi_done2 = 1'b1;
        spi_data2 = {1'b0, m2_ch, 13'h0000};
        m2_pend   = 0;
      end else begin
        m2_cnt--;
      end
    end
    if (spi_start2 === 1'b1) begin
      m2_pend = 1;
      m2_cnt  = 30;
      m2_ch   = spi_ch2;
    end
  end

  // ---------------- monitor (main) ----------------
  int         n_samp = 0, n_start = 0, valid_cyc = 0, terr_cyc = 0;
  bit         terr_seen = 0;
  int         st_cyc [$];
  logic [1:0] st_ch  [$];
  logic [1:0] samp_q [$];

  always @(negedge clk) begin
    if (sval === 1'b1) begin
      n_samp++;
      samp_q.push_back(sch);
      valid_cyc = cyc;
    end
    if (spi_start === 1'b1) begin
      n_start++;
      st_cyc.push_back(cyc);
      st_ch.push_back(spi_ch);
    end
    if (serr[1] === 1'b1 && !terr_seen) begin
      terr_seen = 1;
      terr_cyc  = cyc;
    end
  end

  // ---------------- helpers ----------------
  int n_chk = 0, n_err = 0;

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_samp(input string tag, input int target, input int budget);
    int k = 0;
    while (n_samp < target && k < budget) begin
      step(1);
      k++;
    end
    chk(tag, 32'(n_samp >= target), 32'd1);
  endtask

  task automatic wait_start(input string tag, input int target, input int budget);
    int k = 0;
    while (n_start < target && k < budget) begin
      step(1);
      k++;
    end
    chk(tag, 32'(n_start >= target), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int b, bs, k;
    rst = 1; en = 0; ch_mask = 4'b0000; err_clr = 0;
    rst2 = 1; en2 = 0; ch_mask2 = 4'b1111; err_clr2 = 0;
    spi_done = 0; spi_data = '0; spi_done2 = 0; spi_data2 = '0;
    for (int i = 0; i < 4; i++) m_data[i] = 13'h1000;

    // Reset state
    step(3);
    rst = 0;
    step(1);
    chk("rst_vout", vout, 13'h0000);
    chk("rst_seq_err", serr, 3'b000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_spi_start", spi_start, 1'b0);
    chk("rst_sample_valid", sval, 1'b0);
    chk("rst_spi_ch", spi_ch, 2'd0);

`ifdef ADC_SCHED_AVG_EN
    // Four samples on channel 0 -> one update with their mean
    ch_mask = 4'b0001;
    en = 1;
    for (int j = 0; j < 4; j++) begin
      m_data[0] = 13'h1000 + 13'(4 * j);
      b = n_start;
      wait_start("avg_start", b + 1, 2100);
      step(30);
      if (j == 2) chk("avg_no_early_valid", n_samp, 0);
    end
    chk("avg_one_valid", n_samp, 1);
    chk("avg_vout", vout, 13'd6);
`else
    // Frame A: all channels, distinct data
    m_data[0] = 13'h0001; m_data[1] = 13'h1FFF; m_data[2] = 13'h0ABC; m_data[3] = 13'h1000;
    ch_mask = 4'b1111;
    en = 1;
    wait_samp("frameA_samples", 4, 2500);
    chk("frameA_vout", vout, 13'h1001);
    chk("frameA_temp", temp, 13'h0FFF);
    chk("frameA_vin", vin, 13'h1ABC);
    chk("frameA_iout", iout, 13'h0000);
    chk("frameA_sample_ch_seq", {samp_q[0], samp_q[1], samp_q[2], samp_q[3]}, 8'b00_01_10_11);
    chk("done_to_valid_lat", valid_cyc - done_cyc, 1);
    chk("start_to_start_gap", st_cyc[1] - st_cyc[0], 23);

    // Frame B: -4096 everywhere -> offset binary zero
    for (int i = 0; i < 4; i++) m_data[i] = 13'h1000;
    wait_samp("frameB_samples", 8, 2500);
    chk("frameB_all_zero", {vout, temp, vin, iout}, 52'd0);
    chk("frame_period", st_cyc[4] - st_cyc[0], 2000);

    // Mask 0101, mask change mid-frame ignored
    ch_mask = 4'b0101;
    m_data[2] = 13'h0FFF;
    b = n_start; bs = n_samp;
    wait_start("m0101_first_start", b + 1, 2200);
    ch_mask = 4'b1111;
    wait_samp("m0101_samples", bs + 2, 200);
    step(100);
    chk("m0101_start_count", n_start - b, 2);
    chk("m0101_start_chs", {st_ch[b], st_ch[b+1]}, 4'b00_10);
    chk("m0101_vin", vin, 13'h1FFF);
    chk("m0101_temp", temp, 13'h0000);
    chk("m0101_iout", iout, 13'h0000);

    // ID mismatch on channel 1
    ch_mask = 4'b0111;
    m_badid_ch = 1;
    m_data[1] = 13'h0005;
    b = n_start; bs = n_samp;
    wait_samp("idmis_samples", bs + 2, 2300);
    step(50);
    chk("idmis_seq_err", serr, 3'b001);
    chk("idmis_temp_kept", temp, 13'h0000);
    chk("idmis_start_count", n_start - b, 3);
    chk("idmis_valid_count", n_samp - bs, 2);
    chk("idmis_sample_chs", {samp_q[bs], samp_q[bs+1]}, 4'b00_10);
    m_badid_ch = -1;
    err_clr = 1;
    step(1);
    err_clr = 0;
    chk("err_clr", serr, 3'b000);

    // Timeout on channel 0
    ch_mask = 4'b0011;
    m_nodone_ch = 0;
    terr_seen = 0;
    b = n_start; bs = n_samp;
    wait_start("to_second_start", b + 2, 2300);
    chk("to_flag_delay", terr_cyc - st_cyc[b], 64);
    chk("to_next_start", st_cyc[b+1] - st_cyc[b], 65);
    chk("to_next_ch", st_ch[b+1], 2'd1);
    wait_samp("to_ch1_sample", bs + 1, 100);
    chk("to_seq_err", serr, 3'b010);
    chk("to_sample_ch", samp_q[bs], 2'd1);
    m_nodone_ch = -1;

    // EN dropped mid-frame: in-flight conversion completes, no more issued
    ch_mask = 4'b1111;
    m_data[1] = 13'h0123;
    b = n_start; bs = n_samp;
    wait_start("endrop_ch1_start", b + 2, 2300);
    en = 0;
    wait_samp("endrop_samples", bs + 2, 100);
    step(40);
    chk("endrop_start_count", n_start - b, 2);
    chk("endrop_busy", busy, 1'b0);
    chk("endrop_temp", temp, 13'h1123);

    // Short tick: overrun, clear, reset mid-conversion
    rst2 = 0;
    en2 = 1;
    k = 0;
    while (serr2[2] !== 1'b1 && k < 300) begin step(1); k++; end
    chk("ovr_seq_err", serr2, 3'b100);
    en2 = 0;
    k = 0;
    while (busy2 !== 1'b0 && k < 300) begin step(1); k++; end
    chk("ovr_idle", busy2, 1'b0);
    chk("ovr_vout", vout2, 13'h1000);
    err_clr2 = 1;
    step(1);
    err_clr2 = 0;
    chk("ovr_err_clr", serr2, 3'b000);
    en2 = 1;
    k = 0;
    while (spi_start2 !== 1'b1 && k < 100) begin step(1); k++; end
    chk("rst2_start_seen", spi_start2, 1'b1);
    step(5);
    chk("rst2_busy_before", busy2, 1'b1);
    rst2 = 1;
    en2 = 0;
    step(1);
    rst2 = 0;
    chk("rst2_vout", vout2, 13'h0000);
    chk("rst2_busy", busy2, 1'b0);
    chk("rst2_outputs", {spi_start2, spi_ch2, sval2, sch2, serr2}, 9'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
